// File: rtl/hdmi_timing_gen.sv
// Raster timing generator and pixel-pull stage for the HDMI transmitter's parallel RGB bus.
// Optional colour-bar source is compiled in with HDMI_TIMING_GEN_PATTERN_EN.
module hdmi_timing_gen #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pat_en,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        ufl_clear,
  output logic [23:0] vid_data,
  output logic        vid_de,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        frame_start,
  output logic        underflow,
  output logic [15:0] underflow_cnt,
  output logic        busy
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    r_state, w_state_next;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_running, w_h_last, w_v_last, w_frame_last;
  logic          w_active, w_hs_win, w_vs_win, w_pat_active, w_ufl;
  logic [23:0]   w_bar_rgb;

  logic [23:0]   r_vid_data;
  logic          r_vid_de, r_vid_hs, r_vid_vs, r_frame_start, r_underflow, r_busy;
  logic [15:0]   r_ufl_cnt;

  assign w_running    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_h_last     = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last     = (r_v_cnt == VW'(V_TOTAL - 1));
  assign w_frame_last = w_h_last && w_v_last;
  assign w_active     = w_running && (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign w_hs_win     = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) && (r_h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_win     = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) && (r_v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign pix_ready    = w_active && !w_pat_active;
  assign w_ufl        = pix_ready && !pix_valid;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_state_next = ST_RUN;
      ST_RUN:   if (!enable) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)            w_state_next = ST_RUN;
        else if (w_frame_last) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != ST_IDLE);
    end
  end

  // Leaving DRAIN happens on the last pixel, so the natural wrap already lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!w_running) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

`ifdef HDMI_TIMING_GEN_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic       r_pat_active;
  logic [2:0] w_bar_idx;

  // pat_en is latched only where a frame begins, so a frame is never mixed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pat_active <= 1'b0;
    else if ((r_state == ST_IDLE && enable) || (w_running && w_frame_last))
      r_pat_active <= pat_en;
  end

  always_comb begin
    w_bar_idx = 3'd0;
    for (int i = 1; i < 8; i++)
      if (r_h_cnt >= HW'(i * BAR_W)) w_bar_idx = 3'(i);
  end

  always_comb begin
    case (w_bar_idx)
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  assign w_pat_active = r_pat_active;
`else
  logic w_pat_en_unused;
  assign w_pat_en_unused = pat_en;
  assign w_pat_active    = 1'b0;
  assign w_bar_rgb       = 24'h000000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vid_data    <= 24'h000000;
      r_vid_de      <= 1'b0;
      r_vid_hs      <= ~HS_POL;
      r_vid_vs      <= ~VS_POL;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
      r_ufl_cnt     <= 16'h0000;
    end else begin
      r_vid_de      <= w_active;
      r_vid_data    <= !w_active   ? 24'h000000 :
                       w_pat_active ? w_bar_rgb  :
                       pix_valid    ? pix_data   : 24'h000000;
      r_vid_hs      <= (w_running && w_hs_win) ? HS_POL : ~HS_POL;
      r_vid_vs      <= (w_running && w_vs_win) ? VS_POL : ~VS_POL;
      r_frame_start <= w_running && (r_h_cnt == '0) && (r_v_cnt == '0);
      r_underflow   <= w_ufl;
      if (ufl_clear)
        r_ufl_cnt <= {15'd0, w_ufl};
      else if (w_ufl && (r_ufl_cnt != 16'hFFFF))
        r_ufl_cnt <= r_ufl_cnt + 16'd1;
    end
  end

  assign vid_data      = r_vid_data;
  assign vid_de        = r_vid_de;
  assign vid_hs        = r_vid_hs;
  assign vid_vs        = r_vid_vs;
  assign frame_start   = r_frame_start;
  assign underflow     = r_underflow;
  assign underflow_cnt = r_ufl_cnt;
  assign busy          = r_busy;
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on a reduced raster: timing table, position-based reference model,
// underflow/saturation, drain and (with HDMI_TIMING_GEN_PATTERN_EN) the colour bars.
module tb_hdmi_timing_gen;
  localparam int HA = 128, HFP = 1, HSY = 2, HBP = 1;
  localparam int VA = 61,  VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst, enable, pat_en, pix_valid, ufl_clear;
  logic [23:0] pix_data;
  logic        pix_ready, vid_de, vid_hs, vid_vs, frame_start, underflow, busy;
  logic [23:0] vid_data;
  logic [15:0] underflow_cnt;

  hdmi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pat_en(pat_en),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ufl_clear(ufl_clear), .vid_data(vid_data), .vid_de(vid_de),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .frame_start(frame_start),
    .underflow(underflow), .underflow_cnt(underflow_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   c;
    logic de, hs, vs, fs;
  } vec_t;
  vec_t tbl[16];

  int n_checks = 0;
  int n_pass   = 0;
  int c        = 0;
  int end_pos  = 32'h7FFF_FFFF;
  int m_cnt    = 0;
  int uf_seen  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s c=%0d actual=%h required=%h", name, c, act, exp);
  endtask

  function automatic bit run_at(int pos);
    return (pos >= 0) && (pos < end_pos);
  endfunction
  function automatic int h_of(int pos); return pos % HT; endfunction
  function automatic int v_of(int pos); return (pos / HT) % VT; endfunction
  function automatic bit act_at(int pos);
    return (h_of(pos) < HA) && (v_of(pos) < VA);
  endfunction
  function automatic bit hwin(int pos);
    return (h_of(pos) >= HA + HFP) && (h_of(pos) < HA + HFP + HSY);
  endfunction
  function automatic bit vwin(int pos);
    return (v_of(pos) >= VA + VFP) && (v_of(pos) < VA + VFP + VSY);
  endfunction

  // After clock edge c the outputs show raster position c-2 and the counters sit at c-1.
  task automatic model_check(input logic v, input logic [23:0] d, input logic clr);
    int p, q;
    logic e_de, e_hs, e_vs, e_fs, e_uf, e_busy, e_rdy;
    logic [23:0] e_data;
    p = c - 2;
    q = c - 1;
    e_de   = run_at(p) && act_at(p);
    e_uf   = e_de && !v;
    e_data = (e_de && v) ? d : 24'h0;
    e_hs   = !(run_at(p) && hwin(p));
    e_vs   = !(run_at(p) && vwin(p));
    e_fs   = run_at(p) && (p % FRAME == 0);
    e_busy = run_at(q);
    e_rdy  = run_at(q) && act_at(q);
    if (clr)       m_cnt = e_uf ? 1 : 0;
    else if (e_uf) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    chk("model", {vid_de, vid_hs, vid_vs, frame_start, underflow, busy, pix_ready, vid_data, underflow_cnt},
                 {e_de, e_hs, e_vs, e_fs, e_uf, e_busy, e_rdy, e_data, 16'(m_cnt)});
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].c == c) begin
        chk("tbl_de", vid_de, tbl[i].de);
        chk("tbl_hs", vid_hs, tbl[i].hs);
        chk("tbl_vs", vid_vs, tbl[i].vs);
        chk("tbl_fs", frame_start, tbl[i].fs);
      end
    end
  endtask

  task automatic step(input logic en, input logic v, input logic [23:0] d, input logic clr);
    enable = en; pix_valid = v; pix_data = d; ufl_clear = clr;
    @(posedge clk);
    c++;
    @(negedge clk);
    model_check(v, d, clr);
  endtask

  initial begin
    int  k, pn, sat_extra, drain_c;
    bit  done, drain_set;
    logic en_n, v_n, clr_n;

    tbl[0]  = '{1,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{2,    1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{3,    1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{129,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{130,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{131,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{132,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{133,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{134,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{8054, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{8185, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{8186, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{8317, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{8318, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{8449, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{8450, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; enable = 1'b0; pat_en = 1'b0; pix_valid = 1'b0;
    ufl_clear = 1'b0; pix_data = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", vid_data, 24'h0);
    chk("rst_de", vid_de, 1'b0);
    chk("rst_hs", vid_hs, 1'b1);
    chk("rst_vs", vid_vs, 1'b1);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_uf", underflow, 1'b0);
    chk("rst_cnt", underflow_cnt, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", pix_ready, 1'b0);
    rst = 1'b0;

    // Run one line starved, then hit reset mid-cycle while HS is asserted.
    enable = 1'b1;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (vid_hs === 1'b0) break;
    end
    chk("pre_hs_seen", vid_hs, 1'b0);
    chk("pre_cnt", underflow_cnt, 16'd128);
    chk("pre_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_hs", vid_hs, 1'b1);
    chk("arst_vs", vid_vs, 1'b1);
    chk("arst_de", vid_de, 1'b0);
    chk("arst_cnt", underflow_cnt, 16'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", pix_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0; enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", {busy, vid_de, frame_start}, 3'b000);
    end

    done = 0; drain_set = 0; sat_extra = 0; drain_c = 0;
    while (!done && c < 90000) begin
      pn = c + 1 - 2;
      en_n = drain_set ? 1'b0 : !((c + 1 >= 5 * HT + 10) && (c + 1 < 5 * HT + 15));
      if (pn < 2 * HT)           v_n = 1'b1;
      else if (pn < 2 * HT + 10) v_n = 1'b0;
      else if (pn < 3 * HT)      v_n = 1'b1;
      else if (pn < 8 * HT)      v_n = 1'($urandom % 2);
      else                       v_n = 1'b0;
      if (c + 1 == 2 * HT + 20)                 clr_n = 1'b1;
      else if (pn >= 3 * HT && pn < 8 * HT)     clr_n = ($urandom % 64 == 0);
      else                                      clr_n = 1'b0;
      step(en_n, v_n, 24'($urandom), clr_n);

      if (c >= 2 * HT + 2 && c <= 2 * HT + 12 && underflow === 1'b1) uf_seen++;
      if (c == 2 * HT + 12) begin
        chk("ufl10_cnt", underflow_cnt, 16'd10);
        chk("ufl10_pulses", uf_seen, 10);
      end
      if (c == 2 * HT + 20) chk("ufl_clear_cnt", underflow_cnt, 16'd0);

      if (m_cnt == 65535 && underflow === 1'b1) sat_extra++;
      if (!drain_set && sat_extra >= 300 && ((c - 1) % FRAME) != FRAME - 1) begin
        chk("sat_cnt", underflow_cnt, 16'hFFFF);
        drain_set = 1;
        drain_c = c + 1;
        end_pos = ((drain_c - 2) / FRAME + 1) * FRAME;
      end
      if (drain_set && (c - 1) >= end_pos + 40) begin
        chk("drain_busy", busy, 1'b0);
        chk("drain_de", vid_de, 1'b0);
        done = 1;
      end
    end
    chk("main_done", done, 1'b1);

`ifdef HDMI_TIMING_GEN_PATTERN_EN
    begin
      logic [23:0] bars [8];
      bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
      bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
      ufl_clear = 1'b1; enable = 1'b0;
      @(negedge clk);
      ufl_clear = 1'b0;
      chk("pat_pre_cnt", underflow_cnt, 16'h0);
      pat_en = 1'b1; enable = 1'b1;
      for (int kk = 1; kk <= 2 * HT; kk++) begin
        pix_valid = 1'($urandom % 2);
        pix_data  = 24'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk("pat_ready", pix_ready, 1'b0);
        chk("pat_uf", underflow, 1'b0);
        if (kk - 2 >= 0 && kk - 2 < HA) begin
          chk("pat_data", vid_data, bars[(kk - 2) / (HA / 8)]);
          chk("pat_de", vid_de, 1'b1);
        end
      end
      chk("pat_cnt", underflow_cnt, 16'h0);
      enable = 1'b0; pat_en = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
